// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews one N-element vector per accept into a diagonal wavefront (lane i delayed i cycles), zero-padding idle/bubble/flush cycles.
// Define SYSTOLIC_SKEW_FEEDER_PERF_EN to add a saturating bubble_cnt of STREAM cycles without an accept.
module systolic_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int DRAIN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_last,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    output logic               busy,
    output logic               done
`ifdef SYSTOLIC_SKEW_FEEDER_PERF_EN
    ,
    output logic [15:0]        bubble_cnt
`endif
);
    localparam int CW = $clog2(N + DRAIN) + 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(N + DRAIN - 2);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          acc;

    assign in_ready = !rst && (state_q == IDLE || state_q == STREAM);
    assign acc      = in_valid && in_ready;
    assign busy     = state_q != IDLE;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, STREAM: if (acc) state_d = in_last ? FLUSH : STREAM;
            FLUSH:        state_d = (cnt_q == '0) ? DONE : FLUSH;
            default:      state_d = IDLE;
        endcase
        cnt_d  = (state_d == FLUSH) ? ((state_q == FLUSH) ? cnt_q - 1'b1 : FLUSH_LOAD) : '0;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Lane i is an (i+1)-deep chain; non-accept cycles inject accumulation-neutral zeros.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] dat_q [0:i];
        logic [WIDTH-1:0] dat_d [0:i];
        logic [i:0]       vld_q, vld_d;
        always_comb begin
            dat_d[0] = acc ? in_data[i*WIDTH +: WIDTH] : '0;
            vld_d[0] = acc;
            for (int k = 1; k <= i; k++) begin
                dat_d[k] = dat_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                dat_q <= '{default: '0};
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end
        assign out_data[i*WIDTH +: WIDTH] = dat_q[i];
        assign out_valid[i]               = vld_q[i];
    end

`ifdef SYSTOLIC_SKEW_FEEDER_PERF_EN
    logic [15:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = (state_q == IDLE && state_d == STREAM) ? 16'd0 :
                   (state_q == STREAM && !acc && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;
    end

    always_ff @(posedge clk) begin
        if (rst) bubble_q <= '0;
        else     bubble_q <= bubble_d;
    end

    assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized and directed stimulus checked against a cycle-indexed history model of the skew feeder.
module tb_systolic_skew_feeder;
    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int DRAIN = 4;
    localparam int VW    = N * WIDTH;
    localparam int OW    = VW + N + 2;
    localparam int HL    = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          in_ready, busy, done;
    logic [VW-1:0] out_data;
    logic [N-1:0]  out_valid;
`ifdef SYSTOLIC_SKEW_FEEDER_PERF_EN
    logic [15:0]   bubble_cnt;
`endif

    systolic_skew_feeder #(.WIDTH(WIDTH), .N(N), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_data(out_data),
        .out_valid(out_valid), .busy(busy), .done(done)
`ifdef SYSTOLIC_SKEW_FEEDER_PERF_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    // Model: what was injected at each edge, the edge of the last accept, and whether an operation is streaming.
    int e  = 0;
    int tl = -1000;
    bit streaming = 1'b0;
    logic [15:0]   exp_bub = '0;
    logic [VW-1:0] hist_d [HL];
    logic          hist_v [HL];
    logic [OW-1:0] act_o, exp_o;
    logic          act_r, exp_r;

    function automatic logic [VW-1:0] row(input int k);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(N * k + i + 1);
        return v;
    endfunction

    task automatic tick(input logic v, input logic [VW-1:0] d, input logic l, input logic r);
        logic          acc;
        logic [VW-1:0] ed, h;
        logic [N-1:0]  ev;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        rst      = r;
        #1;
        act_r = in_ready;
        exp_r = !r && !(tl <= e - 1 && e - 1 <= tl + N + DRAIN - 1);
        acc   = v && exp_r;
        @(posedge clk);
        if (r) begin
            streaming = 1'b0;
            tl        = -1000;
            exp_bub   = '0;
            for (int k = 0; k < N; k++)
                if (e - k >= 0) begin
                    hist_d[e-k] = '0;
                    hist_v[e-k] = 1'b0;
                end
        end else if (acc) begin
            hist_d[e] = d;
            hist_v[e] = 1'b1;
            if (l) begin
                tl        = e;
                streaming = 1'b0;
            end else begin
                if (!streaming) exp_bub = '0;
                streaming = 1'b1;
            end
        end else begin
            hist_d[e] = '0;
            hist_v[e] = 1'b0;
            if (streaming && exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            h = (e - i >= 0) ? hist_d[e-i] : '0;
            ed[i*WIDTH +: WIDTH] = h[i*WIDTH +: WIDTH];
            ev[i] = (e - i >= 0) ? hist_v[e-i] : 1'b0;
        end
        exp_o = {ed, ev, e == tl + N + DRAIN - 1, streaming || (tl <= e && e <= tl + N + DRAIN - 1)};
        act_o = {out_data, out_valid, done, busy};
        e++;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, {$urandom, $urandom}, 1'b0, k < 2);
            checks++; if (act_o !== exp_o) $display("FAIL reset out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
            checks++; if (act_r !== exp_r) $display("FAIL reset in_ready k=%0d got %b want %b", k, act_r, exp_r); else passes++;
            if (k < 2) begin
                checks++; if ({act_r, act_o} !== '0) $display("FAIL reset zero k=%0d got %h want 0", k, {act_r, act_o}); else passes++;
            end
        end
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        checks++; if (act_r !== 1'b1 || busy !== 1'b0) $display("FAIL reset release ready/busy got %b%b want 10", act_r, busy); else passes++;
    endtask

    task automatic test_back_to_back();
        int ready_low = 0;
        int done_cnt  = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 4) tick(1'b1, row(k), k == 3, 1'b0);
            else       tick(1'b0, '0, 1'b0, 1'b0);
            checks++; if (act_o !== exp_o) $display("FAIL b2b out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
            checks++; if (act_r !== exp_r) $display("FAIL b2b in_ready k=%0d got %b want %b", k, act_r, exp_r); else passes++;
            if (k < 4) begin
                checks++; if (out_data[15:0] !== 16'(4 * k + 1)) $display("FAIL b2b lane0 k=%0d got %0d want %0d", k, out_data[15:0], 4 * k + 1); else passes++;
            end
            if (k >= 3 && k <= 6) begin
                checks++; if (out_data[63:48] !== 16'(4 * (k - 3) + 4)) $display("FAIL b2b lane3 k=%0d got %0d want %0d", k, out_data[63:48], 4 * (k - 3) + 4); else passes++;
            end
            if (!act_r) ready_low++;
            if (done) done_cnt++;
        end
        checks++; if (ready_low != 8) $display("FAIL b2b ready_low got %0d want 8", ready_low); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL b2b done_pulses got %0d want 1", done_cnt); else passes++;
        checks++; if ({out_data, out_valid} !== '0) $display("FAIL b2b drained got %h want 0", {out_data, out_valid}); else passes++;
    endtask

    task automatic test_bubble();
        logic [15:0] pd [4] = '{16'd1, 16'd0, 16'd0, 16'd2};
        logic        pv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 14; k++) begin
            if (k == 0)      tick(1'b1, {N{16'd1}}, 1'b0, 1'b0);
            else if (k == 3) tick(1'b1, {N{16'd2}}, 1'b1, 1'b0);
            else             tick(1'b0, {$urandom, $urandom}, 1'b1, 1'b0);
            checks++; if (act_o !== exp_o) $display("FAIL bubble out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
            checks++; if (act_r !== exp_r) $display("FAIL bubble in_ready k=%0d got %b want %b", k, act_r, exp_r); else passes++;
            for (int i = 0; i < N; i++)
                if (k - i >= 0 && k - i < 4) begin
                    checks++;
                    if (out_data[i*WIDTH +: WIDTH] !== pd[k-i] || out_valid[i] !== pv[k-i])
                        $display("FAIL bubble lane%0d k=%0d got %0d/%b want %0d/%b", i, k, out_data[i*WIDTH +: WIDTH], out_valid[i], pd[k-i], pv[k-i]);
                    else passes++;
                end
`ifdef SYSTOLIC_SKEW_FEEDER_PERF_EN
            if (k >= 3) begin
                checks++; if (bubble_cnt !== 16'd2) $display("FAIL bubble_cnt k=%0d got %0d want 2", k, bubble_cnt); else passes++;
            end
`endif
        end
    endtask

    task automatic test_single_beat();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) tick(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
            else        tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
            checks++; if (act_o !== exp_o) $display("FAIL single out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
            checks++; if (act_r !== exp_r) $display("FAIL single in_ready k=%0d got %b want %b", k, act_r, exp_r); else passes++;
            checks++; if (done !== (k == 7)) $display("FAIL single done k=%0d got %b want %b", k, done, k == 7); else passes++;
            if (k == 1) begin
                checks++; if (act_r !== 1'b0) $display("FAIL single ready_drop got %b want 0", act_r); else passes++;
            end
        end
    endtask

    task automatic test_signed();
        logic [15:0] pat [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0100};
        for (int k = 0; k < 10; k++) begin
            if (k == 0) tick(1'b1, {pat[3], pat[2], pat[1], pat[0]}, 1'b1, 1'b0);
            else        tick(1'b0, '0, 1'b0, 1'b0);
            checks++; if (act_o !== exp_o) $display("FAIL signed out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
            if (k < N) begin
                checks++; if (out_data[k*WIDTH +: WIDTH] !== pat[k]) $display("FAIL signed lane%0d got %h want %h", k, out_data[k*WIDTH +: WIDTH], pat[k]); else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, row(7), 1'b0, 1'b0);
        tick(1'b1, row(8), 1'b0, 1'b0);
        tick(1'b1, row(9), 1'b0, 1'b1);
        checks++; if ({act_o, done} !== '0) $display("FAIL midreset zero got %h want 0", act_o); else passes++;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            checks++; if (act_o !== exp_o || done !== 1'b0) $display("FAIL midreset out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
        end
        test_back_to_back();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            tick($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
            checks++; if (act_o !== exp_o) $display("FAIL random out k=%0d got %h want %h", k, act_o, exp_o); else passes++;
            checks++; if (act_r !== exp_r) $display("FAIL random in_ready k=%0d got %b want %b", k, act_r, exp_r); else passes++;
`ifdef SYSTOLIC_SKEW_FEEDER_PERF_EN
            checks++; if (bubble_cnt !== exp_bub) $display("FAIL random bubble_cnt k=%0d got %0d want %0d", k, bubble_cnt, exp_bub); else passes++;
`endif
        end
        for (int k = 0; k < 12; k++) tick(1'b0, '0, 1'b0, 1'b0);
        checks++; if (act_o !== exp_o) $display("FAIL random drain got %h want %h", act_o, exp_o); else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubble();
        test_single_beat();
        test_signed();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the systolic matrix-multiply array.
- Accepts one N-element vector per handshake and drives the N edge lanes of the PE grid, one lane per row or column, with lane i delayed i cycles. This is the diagonal wavefront the PEs need.
- One instance feeds the west edge and one feeds the north edge. A shared controller drives both instances in lockstep.
- The block pads with zeros while idle, during bubbles and during flush, and signals completion once the array has drained.

Parameters:
WIDTH, 16, bits per element (signed fixed-point; passed through untouched)
N, 4, number of lanes (array dimension), N >= 2
DRAIN, 4, extra zero cycles after the last lane empties, covering array propagation

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in_data  input  N*WIDTH  vector; element i at [i*WIDTH +: WIDTH]
in_last  input  1  qualifies the final vector of the operation
out_data  output  N*WIDTH  lane i at [i*WIDTH +: WIDTH], to PE edge inputs
out_valid  output  N  per-lane live-data flag
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when the operation has fully drained

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a rising edge) clears, in the same edge:
  - all skew registers;
  - out_data = 0, out_valid = 0, done = 0, busy = 0;
  - state = IDLE, counters = 0.
- in_ready = 0 while rst is high.
- Reset mid-operation discards all in-flight data. No done pulse is issued.
- Accept occurs when in_valid && in_ready at a rising edge.
- Skew structure:
  - lane i is a shift chain of i+1 registers;
  - every stage advances every cycle. There is no stall and no downstream backpressure, because the PE array free-runs.
- Latency: an element accepted at edge t appears on lane i after edge t+i, i.e. lane 0 one cycle after accept.
- Cycles with no accept inject 0 data with valid 0 into stage 0 of every lane. Zero is accumulation-neutral in the PEs.
- Data is not modified: no sign handling, no saturation.
- FSM:
  - IDLE: in_ready=1. Accept without in_last goes to STREAM. Accept with in_last goes to FLUSH. No accept stays in IDLE.
  - STREAM: in_ready=1. Accept with in_last goes to FLUSH. Other accepts and bubbles stay in STREAM.
  - FLUSH: in_ready=0; in_valid is ignored. A counter loads N-1+DRAIN-1 on entry and decrements each cycle. When it reaches 0, go to DONE, so FLUSH lasts exactly N-1+DRAIN cycles.
  - DONE: in_ready=0, done=1 for exactly this one cycle, then go to IDLE.
- busy = 1 in STREAM, FLUSH and DONE.
- done is registered, so it is high in the cycle the state is DONE.
- in_last without in_valid has no effect.
- A new operation may be accepted in the first IDLE cycle after DONE.
- Lockstep between the west and north instances is the controller's responsibility. The block does not check it.

Optional Feature:
- Macro: SYSTOLIC_SKEW_FEEDER_PERF_EN.
- When defined, adds output port bubble_cnt (16 bits). It counts STREAM cycles with no accept and saturates at 16'hFFFF.
- bubble_cnt clears on rst and on entry to STREAM from IDLE. It holds its value in FLUSH, DONE and IDLE.
- When not defined, the port and counter do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> in_ready=0, out_data=0, out_valid=0, done=0, busy=0. After release: in_ready=1, state IDLE.
- Back-to-back (N=4, DRAIN=4): accept rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}(last) at edges t..t+3.
  - Lane 0 shows 1,5,9,13 after edges t..t+3.
  - Lane 3 shows 4,8,12,16 after edges t+3..t+6.
  - in_ready=0 for 7 FLUSH cycles plus 1 DONE cycle; done pulses once; all lanes return to 0.
- Bubble: accept {1,1,1,1}, deassert in_valid for 2 cycles, accept {2,2,2,2}(last) -> every lane shows 1,0,0,2 in consecutive cycles with out_valid pattern 1,0,0,1. bubble_cnt=2 when the macro is defined.
- Single beat: in_last on the first accept in IDLE -> direct transition to FLUSH, in_ready drops the next cycle, done 8 cycles after accept.
- Signed passthrough: accept {16'h8000,16'hFFFF,16'h7FFF,16'h0100} -> identical bit patterns appear on lanes 0..3 at their skewed cycles.
- Reset mid-stream: after 2 accepts, assert rst -> all outputs 0 the next cycle, no done pulse, and a subsequent operation behaves as in the back-to-back scenario.
